// File: rtl/sdram_field_writer.sv
// Feeds write port 1 of the SDRAM controller from the decoded interlaced pixel stream.
// Both fields are stored field-sequentially, and every stored line is clipped or padded to H_ACTIVE words.
module sdram_field_writer #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned FIELD_LINES = 288,
  parameter logic [21:0] BASE_ADDR   = 22'd0,
  parameter int unsigned BURST_LEN   = 128,
  parameter int unsigned LOAD_CYCLES = 4,
  parameter logic [15:0] PAD_DATA    = 16'h8010
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [15:0] iDATA,
  input  logic        iDVAL,
  input  logic        iFIELD,
  input  logic        iEN,
  input  logic        iWR_FULL,
  output logic [15:0] oWR_DATA,
  output logic        oWR,
  output logic        oWR_LOAD,
  output logic [21:0] oWR_ADDR,
  output logic [8:0]  oWR_LENGTH,
  output logic        oOVF,
  output logic [7:0]  oFRAME_CNT,
  output logic        oBUSY
);

  localparam logic [21:0] FIELD1_ADDR = BASE_ADDR + 22'(H_ACTIVE * FIELD_LINES);
  localparam logic [10:0] PIX_END     = 11'(H_ACTIVE);
  localparam logic [10:0] PIX_LAST    = 11'(H_ACTIVE - 1);
  localparam logic [15:0] LINE_LAST   = 16'(FIELD_LINES - 1);
  localparam logic [15:0] LOAD_LAST   = 16'(LOAD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, ACTIVE, PAD} state_t;

  state_t      state, state_n;
  logic [10:0] pix, pix_n;
  logic [15:0] line_cnt, line_n;
  logic [15:0] load_cnt, load_cnt_n;
  logic [21:0] addr, addr_n;
  logic        cur_field, cur_field_n;
  logic [7:0]  frame_cnt, frame_cnt_n;
  logic        ovf, ovf_n;
  logic        field_p1, dval_p1;
  logic        wr_p1, wr_n;
  logic [15:0] wr_data_p1, wr_data_n;

  logic        fstart, dval_fall;
  logic        wr_req, pad_step, line_done, abort, go_load;
  logic [15:0] wr_val;

  assign fstart    = field_p1 != iFIELD;
  assign dval_fall = dval_p1 && !iDVAL;

  always_comb begin
    state_n     = state;
    pix_n       = pix;
    line_n      = line_cnt;
    load_cnt_n  = load_cnt;
    addr_n      = addr;
    cur_field_n = cur_field;
    frame_cnt_n = frame_cnt;
    ovf_n       = ovf;
    wr_n        = 1'b0;
    wr_data_n   = wr_data_p1;
    wr_req      = 1'b0;
    wr_val      = PAD_DATA;
    pad_step    = 1'b0;
    line_done   = 1'b0;
    abort       = 1'b0;
    go_load     = 1'b0;

    case (state)
      IDLE: begin
        if (!iEN) ovf_n = 1'b0;
        if (fstart && iEN) go_load = 1'b1;
      end
      LOAD: begin
        if (fstart) begin
          go_load = 1'b1;
        end else if (load_cnt == LOAD_LAST) begin
          state_n = ACTIVE;
          pix_n   = '0;
          line_n  = '0;
        end else begin
          load_cnt_n = load_cnt + 16'd1;
        end
      end
      ACTIVE: begin
        if (fstart) begin
          abort = 1'b1;
        end else if (iDVAL) begin
          if (pix < PIX_END) begin
            wr_req = 1'b1;
            wr_val = iDATA;
            pix_n  = pix + 11'd1;
          end
        end else if (dval_fall && pix != '0) begin
          // The first pad word goes out on the fall cycle so padding follows the data without a gap.
          if (pix < PIX_END) begin
            wr_req   = 1'b1;
            pad_step = 1'b1;
          end else begin
            line_done = 1'b1;
          end
        end
      end
      PAD: begin
        if (fstart) begin
          abort = 1'b1;
        end else begin
          if (iDVAL) ovf_n = 1'b1;
          wr_req   = 1'b1;
          pad_step = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (pad_step) begin
      if (pix == PIX_LAST) begin
        line_done = 1'b1;
      end else begin
        pix_n   = pix + 11'd1;
        state_n = PAD;
      end
    end

    if (line_done) begin
      pix_n = '0;
      if (line_cnt == LINE_LAST) begin
        line_n  = '0;
        state_n = IDLE;
        if (cur_field) frame_cnt_n = frame_cnt + 8'd1;
      end else begin
        line_n  = line_cnt + 16'd1;
        state_n = ACTIVE;
      end
    end

    if (abort) begin
      if (iEN) go_load = 1'b1;
      else     state_n = IDLE;
    end

    if (go_load) begin
      state_n     = LOAD;
      load_cnt_n  = '0;
      pix_n       = '0;
      line_n      = '0;
      cur_field_n = iFIELD;
      addr_n      = iFIELD ? FIELD1_ADDR : BASE_ADDR;
    end

    // A write refused by a full FIFO still consumes its pixel slot to keep lines aligned.
    if (wr_req) begin
      if (iWR_FULL) begin
        ovf_n = 1'b1;
      end else begin
        wr_n      = 1'b1;
        wr_data_n = wr_val;
      end
    end
  end

  // p1: registered control state and FIFO write stage
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= IDLE;
      pix        <= '0;
      line_cnt   <= '0;
      load_cnt   <= '0;
      addr       <= BASE_ADDR;
      cur_field  <= 1'b0;
      frame_cnt  <= '0;
      ovf        <= 1'b0;
      field_p1   <= 1'b0;
      dval_p1    <= 1'b0;
      wr_p1      <= 1'b0;
      wr_data_p1 <= '0;
    end else begin
      state      <= state_n;
      pix        <= pix_n;
      line_cnt   <= line_n;
      load_cnt   <= load_cnt_n;
      addr       <= addr_n;
      cur_field  <= cur_field_n;
      frame_cnt  <= frame_cnt_n;
      ovf        <= ovf_n;
      field_p1   <= iFIELD;
      dval_p1    <= iDVAL;
      wr_p1      <= wr_n;
      wr_data_p1 <= wr_data_n;
    end
  end

  assign oWR        = wr_p1;
  assign oWR_DATA   = wr_data_p1;
  assign oWR_LOAD   = !RESET_N || (state == LOAD);
  assign oWR_ADDR   = addr;
  assign oWR_LENGTH = 9'(BURST_LEN);
  assign oOVF       = ovf;
  assign oFRAME_CNT = frame_cnt;
  assign oBUSY      = state != IDLE;

endmodule

// File: tb/tb_sdram_field_writer.sv
// Bench for sdram_field_writer: scoreboard of expected FIFO words plus per-scenario tasks.
// Uses a short field (12 lines) and a base address near the top of memory so the field-1 address wraps.
module tb_sdram_field_writer;

  localparam int          H       = 640;
  localparam int          LINES   = 12;
  localparam logic [21:0] BASE    = 22'h3FF000;
  localparam logic [21:0] F1_ADDR = 22'h000E00;
  localparam logic [15:0] PAD     = 16'h8010;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [15:0] iDATA = '0;
  logic        iDVAL = 1'b0;
  logic        iFIELD = 1'b0;
  logic        iEN = 1'b0;
  logic        iWR_FULL = 1'b0;
  logic [15:0] oWR_DATA;
  logic        oWR;
  logic        oWR_LOAD;
  logic [21:0] oWR_ADDR;
  logic [8:0]  oWR_LENGTH;
  logic        oOVF;
  logic [7:0]  oFRAME_CNT;
  logic        oBUSY;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  logic [15:0] exp_q[$];

  sdram_field_writer #(
    .H_ACTIVE(H), .FIELD_LINES(LINES), .BASE_ADDR(BASE),
    .BURST_LEN(128), .LOAD_CYCLES(4), .PAD_DATA(PAD)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .iDATA(iDATA), .iDVAL(iDVAL), .iFIELD(iFIELD),
    .iEN(iEN), .iWR_FULL(iWR_FULL), .oWR_DATA(oWR_DATA), .oWR(oWR),
    .oWR_LOAD(oWR_LOAD), .oWR_ADDR(oWR_ADDR), .oWR_LENGTH(oWR_LENGTH),
    .oOVF(oOVF), .oFRAME_CNT(oFRAME_CNT), .oBUSY(oBUSY)
  );

  always #5 CLK = ~CLK;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Scoreboard: every FIFO write must match the oldest expected word.
  always @(negedge CLK) begin
    if (oWR === 1'b1) begin
      wr_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got data %h, expected no write", oWR_DATA);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (oWR_DATA !== e || oWR_LOAD !== 1'b0) begin
          errors++;
          $display("FAIL wr_data: got %h load=%b, expected %h load=0", oWR_DATA, oWR_LOAD, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drives one line of n pixels (FIFO full for pixels full_at..full_at+full_len-1),
  // then blanking long enough for any padding; reports writes seen and the pad run length.
  task automatic drive_line(input int n, input int full_at, input int full_len,
                            output int got, output int pad_run);
    int start;
    bit done;
    logic [15:0] d;
    start = wr_count;
    for (int i = 0; i < n; i++) begin
      d = 16'($urandom);
      iDVAL = 1'b1;
      iDATA = d;
      iWR_FULL = (i >= full_at) && (i < full_at + full_len);
      if (i < H && !iWR_FULL) exp_q.push_back(d);
      tick();
    end
    iDVAL = 1'b0;
    iDATA = '0;
    iWR_FULL = 1'b0;
    for (int k = n; k < H; k++) exp_q.push_back(PAD);
    pad_run = 0;
    done = 1'b0;
    for (int j = 0; j < ((n < H) ? H - n : 0) + 4; j++) begin
      tick();
      if (!done && oWR === 1'b1) pad_run++;
      else done = 1'b1;
    end
    got = wr_count - start;
  endtask

  task automatic start_field(input logic f, input logic [21:0] exp_addr);
    int n;
    logic [21:0] a;
    iFIELD = f;
    n = 0;
    a = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (oWR_LOAD === 1'b1) begin
        n++;
        a = oWR_ADDR;
      end
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL load_len: got %0d cycles, expected 4", n);
    end
    checks++;
    if (a !== exp_addr) begin
      errors++;
      $display("FAIL load_addr: got %h, expected %h", a, exp_addr);
    end
    checks++;
    if (oBUSY !== 1'b1) begin
      errors++;
      $display("FAIL busy_active: got %b, expected 1", oBUSY);
    end
  endtask

  task automatic run_field(input logic f, input logic [21:0] exp_addr);
    int s, got, run;
    start_field(f, exp_addr);
    s = wr_count;
    for (int l = 0; l < LINES; l++) begin
      drive_line(H, 0, 0, got, run);
      checks++;
      if (got != H) begin
        errors++;
        $display("FAIL line_writes: line %0d got %0d, expected %0d", l, got, H);
      end
    end
    checks++;
    if (wr_count - s != H * LINES) begin
      errors++;
      $display("FAIL field_writes: got %0d, expected %0d", wr_count - s, H * LINES);
    end
    checks++;
    if (oBUSY !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL field_end: busy %b pending %0d, expected busy 0 pending 0", oBUSY, exp_q.size());
    end
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    repeat (3) tick();
    checks++;
    if (oWR !== 1'b0 || oWR_DATA !== 16'h0 || oOVF !== 1'b0 || oFRAME_CNT !== 8'd0 || oBUSY !== 1'b0) begin
      errors++;
      $display("FAIL reset_outs: got wr=%b data=%h ovf=%b frame=%0d busy=%b, expected all 0",
               oWR, oWR_DATA, oOVF, oFRAME_CNT, oBUSY);
    end
    checks++;
    if (oWR_LOAD !== 1'b1) begin
      errors++;
      $display("FAIL reset_load: got %b, expected 1", oWR_LOAD);
    end
    checks++;
    if (oWR_ADDR !== BASE || oWR_LENGTH !== 9'd128) begin
      errors++;
      $display("FAIL reset_addr_len: got %h/%0d, expected %h/128", oWR_ADDR, oWR_LENGTH, BASE);
    end
    RESET_N = 1'b1;
    #1;
    checks++;
    if (oWR_LOAD !== 1'b0) begin
      errors++;
      $display("FAIL release_load: got %b, expected 0", oWR_LOAD);
    end
  endtask

  task automatic test_fields();
    iEN = 1'b0;
    iFIELD = 1'b1;
    repeat (6) tick();
    checks++;
    if (oBUSY !== 1'b0 || oWR_LOAD !== 1'b0) begin
      errors++;
      $display("FAIL disabled_edge: got busy %b load %b, expected 0 0", oBUSY, oWR_LOAD);
    end
    iEN = 1'b1;
    run_field(1'b0, BASE);
    checks++;
    if (oFRAME_CNT !== 8'd0) begin
      errors++;
      $display("FAIL frame_after_f0: got %0d, expected 0", oFRAME_CNT);
    end
    run_field(1'b1, F1_ADDR);
    checks++;
    if (oFRAME_CNT !== 8'd1) begin
      errors++;
      $display("FAIL frame_after_f1: got %0d, expected 1", oFRAME_CNT);
    end
    run_field(1'b0, BASE);
    checks++;
    if (oFRAME_CNT !== 8'd1) begin
      errors++;
      $display("FAIL frame_after_f0b: got %0d, expected 1", oFRAME_CNT);
    end
  endtask

  task automatic test_line_lengths();
    int got, run;
    start_field(1'b1, F1_ADDR);
    drive_line(600, 0, 0, got, run);
    checks++;
    if (got != 640 || run != 40) begin
      errors++;
      $display("FAIL short_line: got %0d writes pad run %0d, expected 640 and 40", got, run);
    end
    drive_line(640, 0, 0, got, run);
    checks++;
    if (got != 640) begin
      errors++;
      $display("FAIL after_pad_line: got %0d, expected 640", got);
    end
    drive_line(700, 0, 0, got, run);
    checks++;
    if (got != 640 || oOVF !== 1'b0) begin
      errors++;
      $display("FAIL long_line: got %0d writes ovf %b, expected 640 and 0", got, oOVF);
    end
    drive_line(640, 100, 10, got, run);
    checks++;
    if (got != 630 || oOVF !== 1'b1) begin
      errors++;
      $display("FAIL full_line: got %0d writes ovf %b, expected 630 and 1", got, oOVF);
    end
  endtask

  task automatic test_field_toggle();
    int got, run, n;
    logic [21:0] first_a, last_a;
    drive_line(640, 0, 0, got, run);
    start_field(1'b0, BASE);
    checks++;
    if (oFRAME_CNT !== 8'd1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL abort_frame: got frame %0d pending %0d, expected 1 and 0", oFRAME_CNT, exp_q.size());
    end
    drive_line(640, 0, 0, got, run);
    checks++;
    if (got != 640) begin
      errors++;
      $display("FAIL after_abort_line: got %0d, expected 640", got);
    end
    iFIELD = 1'b1;
    n = 0;
    first_a = '0;
    last_a = '0;
    for (int i = 0; i < 12; i++) begin
      if (i == 2) iFIELD = 1'b0;
      tick();
      if (oWR_LOAD === 1'b1) begin
        if (n == 0) first_a = oWR_ADDR;
        last_a = oWR_ADDR;
        n++;
      end
    end
    checks++;
    if (n != 6 || first_a !== F1_ADDR || last_a !== BASE) begin
      errors++;
      $display("FAIL load_restart: got %0d cycles %h->%h, expected 6 cycles %h->%h",
               n, first_a, last_a, F1_ADDR, BASE);
    end
    checks++;
    if (oOVF !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got %b, expected 1", oOVF);
    end
    iEN = 1'b0;
    iFIELD = 1'b1;
    repeat (3) tick();
    checks++;
    if (oBUSY !== 1'b0 || oOVF !== 1'b0 || oFRAME_CNT !== 8'd1) begin
      errors++;
      $display("FAIL disable_abort: got busy %b ovf %b frame %0d, expected 0 0 1", oBUSY, oOVF, oFRAME_CNT);
    end
  endtask

  task automatic test_reset_mid_pad();
    logic [15:0] d;
    iEN = 1'b1;
    start_field(1'b0, BASE);
    for (int i = 0; i < 600; i++) begin
      d = 16'($urandom);
      iDVAL = 1'b1;
      iDATA = d;
      exp_q.push_back(d);
      tick();
    end
    iDVAL = 1'b0;
    iDATA = '0;
    for (int k = 0; k < 40; k++) exp_q.push_back(PAD);
    repeat (5) tick();
    iDVAL = 1'b1;
    iDATA = 16'h1234;
    tick();
    iDVAL = 1'b0;
    iDATA = '0;
    repeat (2) tick();
    checks++;
    if (oOVF !== 1'b1 || oWR !== 1'b1) begin
      errors++;
      $display("FAIL pad_drop: got ovf %b wr %b, expected 1 1", oOVF, oWR);
    end
    RESET_N = 1'b0;
    #1;
    checks++;
    if (oWR !== 1'b0 || oWR_LOAD !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_pad: got wr %b load %b, expected 0 1", oWR, oWR_LOAD);
    end
    checks++;
    if (oBUSY !== 1'b0 || oOVF !== 1'b0 || oFRAME_CNT !== 8'd0 || oWR_ADDR !== BASE || oWR_DATA !== 16'h0) begin
      errors++;
      $display("FAIL reset_in_pad_outs: got busy %b ovf %b frame %0d addr %h data %h, expected 0 0 0 %h 0000",
               oBUSY, oOVF, oFRAME_CNT, oWR_ADDR, oWR_DATA, BASE);
    end
    exp_q.delete();
    repeat (3) tick();
    checks++;
    if (oWR_LOAD !== 1'b1) begin
      errors++;
      $display("FAIL reset_hold_load: got %b, expected 1", oWR_LOAD);
    end
    RESET_N = 1'b1;
    #1;
    checks++;
    if (oWR_LOAD !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_load: got %b, expected 0", oWR_LOAD);
    end
    repeat (4) tick();
    checks++;
    if (oWR !== 1'b0 || oBUSY !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got wr %b busy %b, expected 0 0", oWR, oBUSY);
    end
  endtask

  initial begin
    test_reset();
    test_fields();
    test_line_lengths();
    test_field_toggle();
    test_reset_mid_pad();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
